// File: rtl/wb_host_master_if.sv
// Command/response handshake and Wishbone classic signals for wb_host_master.
interface wb_host_master_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [DW-1:0] cmd_dat;
  logic [SW-1:0] cmd_sel;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_dat;
  logic          rsp_err;

  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic [SW-1:0] wbm_sel_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic [DW-1:0] wbm_dat_i;
  logic          wbm_ack_i;

  // Host side: takes commands, returns responses, drives the bus.
  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
    input  wbm_dat_i, wbm_ack_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  // Command source and Wishbone target side.
  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
    output wbm_dat_i, wbm_ack_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle,
// one response out, with an optional ACK timeout and saturating error count.
module wb_host_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  wb_host_master_if.master    bus,
  output logic [7:0]          err_count
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned EW    = 8;

  localparam bit             TMO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [AW-1:0]    adr_q, adr_d;
  logic [DW-1:0]    dat_q, dat_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rsp_dat_q, rsp_dat_d;
  logic             rsp_err_q, rsp_err_d;
  logic [EW-1:0]    err_q, err_d;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    err_d       = err_q;
    cmd_ready_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          we_d    = bus.cmd_we;
          sel_d   = bus.cmd_sel;
          adr_d   = bus.cmd_adr;
          dat_d   = bus.cmd_dat;
          cnt_d   = '0;
          cyc_d   = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        // ACK takes priority over a timeout firing in the same cycle.
        if (bus.wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? '0 : bus.wbm_dat_i;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          if (err_q != '1) begin
            err_d = err_q + EW'(1);
          end
          state_d     = RESP;
        end else if (TMO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset drops any transfer in flight.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      err_q       <= err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dat   = rsp_dat_q;
  assign bus.rsp_err   = rsp_err_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Randomized and directed bench for wb_host_master; three instances cover
// TIMEOUT = 8, 4 and 0, one active at a time through a shared stimulus mux.
module tb_wb_host_master;

  localparam int unsigned NDUT = 3;

  function automatic int unsigned tmo_of(input int i);
    case (i)
      0:       return 8;
      1:       return 4;
      default: return 0;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  dsel;
  logic        cmd_valid, cmd_we, rsp_ready, ack;
  logic [31:0] cmd_adr, cmd_dat, dat_i;
  logic [3:0]  cmd_sel;

  logic        o_cmd_ready [NDUT];
  logic        o_cyc       [NDUT];
  logic        o_stb       [NDUT];
  logic        o_we        [NDUT];
  logic [3:0]  o_sel       [NDUT];
  logic [31:0] o_adr       [NDUT];
  logic [31:0] o_dat       [NDUT];
  logic        o_rv        [NDUT];
  logic [31:0] o_rdat      [NDUT];
  logic        o_rerr      [NDUT];
  logic [7:0]  o_ec        [NDUT];

  wb_host_master_if bus [NDUT] ();

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign bus[g].cmd_valid = cmd_valid && (dsel == 2'(g));
    assign bus[g].cmd_we    = cmd_we;
    assign bus[g].cmd_adr   = cmd_adr;
    assign bus[g].cmd_dat   = cmd_dat;
    assign bus[g].cmd_sel   = cmd_sel;
    assign bus[g].rsp_ready = rsp_ready && (dsel == 2'(g));
    assign bus[g].wbm_ack_i = ack && (dsel == 2'(g));
    assign bus[g].wbm_dat_i = dat_i;

    wb_host_master #(.TIMEOUT(tmo_of(g))) u_dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .bus       (bus[g]),
      .err_count (o_ec[g])
    );

    assign o_cmd_ready[g] = bus[g].cmd_ready;
    assign o_cyc[g]       = bus[g].wbm_cyc_o;
    assign o_stb[g]       = bus[g].wbm_stb_o;
    assign o_we[g]        = bus[g].wbm_we_o;
    assign o_sel[g]       = bus[g].wbm_sel_o;
    assign o_adr[g]       = bus[g].wbm_adr_o;
    assign o_dat[g]       = bus[g].wbm_dat_o;
    assign o_rv[g]        = bus[g].rsp_valid;
    assign o_rdat[g]      = bus[g].rsp_dat;
    assign o_rerr[g]      = bus[g].rsp_err;
  end

  logic        s_cmd_ready, s_cyc, s_stb, s_we, s_rv, s_rerr;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat, s_rdat;
  logic [7:0]  s_ec;

  always_comb begin
    s_cmd_ready = o_cmd_ready[dsel];
    s_cyc       = o_cyc[dsel];
    s_stb       = o_stb[dsel];
    s_we        = o_we[dsel];
    s_sel       = o_sel[dsel];
    s_adr       = o_adr[dsel];
    s_dat       = o_dat[dsel];
    s_rv        = o_rv[dsel];
    s_rdat      = o_rdat[dsel];
    s_rerr      = o_rerr[dsel];
    s_ec        = o_ec[dsel];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ec [NDUT];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut=%0d got=%h exp=%h", tag, dsel, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: STB-high cycle count for a slave that ACKs in STB cycle w+1
  // (w<0 means never). -1 means the transfer never ends.
  function automatic int exp_stb_cycles(input int t, input int w);
    if (w >= 0 && (t == 0 || w + 1 <= t)) return w + 1;
    if (t != 0) return t;
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, s_cmd_ready, 0);
    check({tag, "_cyc"}, s_cyc, 0);
    check({tag, "_stb"}, s_stb, 0);
    check({tag, "_rv"}, s_rv, 0);
    check({tag, "_rdat"}, s_rdat, 0);
    check({tag, "_rerr"}, s_rerr, 0);
    check({tag, "_ec"}, s_ec, 0);
    check({tag, "_adr"}, s_adr, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    ack = 1'b0;
    rsp_ready = 1'b0;
    step();
    check_all_zero("rst");
    rst = 1'b0;
    step();
    check("rst_release_cmd_ready", s_cmd_ready, 1);
    for (int i = 0; i < int'(NDUT); i++) exp_ec[i] = 0;
  endtask

  task automatic do_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int w, input logic [31:0] rdata,
                         input int bp, input bit hold_valid);
    int t, n_exp, k, cnt;
    bit err;
    logic [31:0] exp_rd;
    t     = int'(tmo_of(int'(dsel)));
    n_exp = exp_stb_cycles(t, w);
    err   = (n_exp >= 0) && !(w >= 0 && w + 1 == n_exp);
    k = 0;
    while (!s_cmd_ready && k < 20) begin
      step();
      k++;
    end
    check("cmd_ready_idle", s_cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    step();
    if (!hold_valid) cmd_valid = 1'b0;
    cnt = 0;
    while (s_stb && cnt < 400) begin
      check("bus_adr", s_adr, adr);
      check("bus_dat", s_dat, dat);
      check("bus_we", s_we, we);
      check("bus_sel", s_sel, sel);
      check("bus_cyc", s_cyc, 1);
      check("bus_cmd_ready", s_cmd_ready, 0);
      cnt++;
      if (n_exp < 0 && cnt >= 300) break;
      ack   = (w >= 0 && cnt == w + 1);
      dat_i = ack ? rdata : $urandom;
      step();
      ack = 1'b0;
    end
    if (n_exp < 0) begin
      check("hang_stb_cycles", cnt, 300);
      check("hang_stb", s_stb, 1);
      check("hang_rv", s_rv, 0);
      check("hang_ec", s_ec, exp_ec[dsel]);
      do_reset();
      return;
    end
    check("stb_cycles", cnt, n_exp);
    if (err && exp_ec[dsel] < 255) exp_ec[dsel]++;
    exp_rd = (err || we) ? 32'h0 : rdata;
    check("rsp_valid", s_rv, 1);
    check("rsp_dat", s_rdat, exp_rd);
    check("rsp_err", s_rerr, err);
    check("err_count", s_ec, exp_ec[dsel]);
    check("rsp_cyc", s_cyc, 0);
    check("rsp_cmd_ready", s_cmd_ready, 0);
    rsp_ready = 1'b0;
    for (int i = 0; i < bp; i++) begin
      step();
      check("bp_rsp_valid", s_rv, 1);
      check("bp_rsp_dat", s_rdat, exp_rd);
      check("bp_rsp_err", s_rerr, err);
      check("bp_cmd_ready", s_cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("post_rsp_valid", s_rv, 0);
    check("post_cmd_ready", s_cmd_ready, 1);
  endtask

  initial begin
    int w, bp;
    bit we;
    rst = 1'b1; dsel = 2'd0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; ack = 1'b0; dat_i = '0;
    for (int i = 0; i < int'(NDUT); i++) exp_ec[i] = 0;
    step();
    step();
    for (int i = 0; i < int'(NDUT); i++) begin
      dsel = 2'(i);
      #1;
      check_all_zero("reset");
    end
    dsel = 2'd0;
    rst = 1'b0;
    step();
    check("first_cmd_ready", s_cmd_ready, 1);

    // TIMEOUT=8 instance
    do_xfer(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 0, 1'b0);
    do_xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, 3, 32'h1234_5678, 0, 1'b0);
    do_xfer(1'b0, 32'h3000_000C, 32'h0, 4'hF, -1, 32'h0, 0, 1'b0);
    check("ec_after_timeout", s_ec, 1);
    do_xfer(1'b0, 32'h3000_0010, 32'h0, 4'h3, 2, 32'hCAFE_F00D, 0, 1'b0);
    do_xfer(1'b0, 32'h3000_0014, 32'h0, 4'hF, 1, 32'hA5A5_5A5A, 5, 1'b1);
    do_xfer(1'b1, 32'h3000_0018, 32'h0BAD_CAFE, 4'hC, 0, 32'h0, 0, 1'b0);

    // Reset in the second BUS cycle of a read, then a late ACK
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0020; cmd_sel = 4'hF;
    step();
    cmd_valid = 1'b0;
    check("mid_stb1", s_stb, 1);
    step();
    check("mid_stb2", s_stb, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_cyc", s_cyc, 0);
    check("mid_rst_stb", s_stb, 0);
    check("mid_rst_rv", s_rv, 0);
    check("mid_rst_cmd_ready", s_cmd_ready, 0);
    check("mid_rst_ec", s_ec, 0);
    for (int i = 0; i < int'(NDUT); i++) exp_ec[i] = 0;
    ack = 1'b1; dat_i = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      step();
      check("late_ack_rv", s_rv, 0);
      check("late_ack_stb", s_stb, 0);
    end
    ack = 1'b0;
    check("late_ack_cmd_ready", s_cmd_ready, 1);

    // TIMEOUT=4 instance: ACK on the firing cycle wins, one cycle later loses
    dsel = 2'd1;
    #1;
    do_xfer(1'b0, 32'h3000_0100, 32'h0, 4'hF, 3, 32'h0F0F_0F0F, 0, 1'b0);
    check("tie_ec", s_ec, 0);
    do_xfer(1'b0, 32'h3000_0104, 32'h0, 4'hF, 4, 32'h1111_2222, 0, 1'b0);

    // TIMEOUT=0 instance: long wait completes, no-ACK hangs without error
    dsel = 2'd2;
    #1;
    do_xfer(1'b0, 32'h3000_0200, 32'h0, 4'hF, 20, 32'h7777_8888, 1, 1'b0);
    do_xfer(1'b0, 32'h3000_0204, 32'h0, 4'hF, -1, 32'h0, 0, 1'b0);

    // Randomized transfers across all instances
    for (int n = 0; n < 150; n++) begin
      dsel = 2'($urandom_range(0, 2));
      #1;
      w = int'($urandom_range(0, 12));
      if (dsel != 2'd2 && $urandom_range(0, 7) == 0) w = -1;
      bp = int'($urandom_range(0, 3));
      we = 1'($urandom);
      do_xfer(we, $urandom, $urandom, 4'($urandom), w, $urandom, bp, 1'b0);
    end

    // Saturate err_count on the TIMEOUT=4 instance, then a good read
    dsel = 2'd1;
    #1;
    for (int n = 0; n < 260; n++) begin
      do_xfer(1'b0, 32'h3000_0300, 32'h0, 4'hF, -1, 32'h0, 0, 1'b0);
    end
    check("ec_saturated", s_ec, 255);
    do_xfer(1'b0, 32'h3000_0304, 32'h0, 4'hF, 0, 32'h5555_AAAA, 0, 1'b0);
    check("ec_hold_sat", s_ec, 255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_host_master.md
Name: wb_host_master

Overview:
- Wishbone classic single-transfer initiator that drives the WB MI A slave port of user_project from the other end of the bus.
- Accepts one command at a time on a valid/ready interface and runs exactly one Wishbone cycle per command.
- Returns read data or a timeout error on a valid/ready response interface.
- Used as the bus host in bring-up and standalone test harnesses where no management SoC is present.

Parameters:
- TIMEOUT, 255, cycles STB may stay high without ACK before the transfer is aborted; 0 disables the timeout. Legal range 0..65535.

Ports:
- wb_clk_i  in  1  single clock, rising edge
- wb_rst_i  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  32  byte address
- cmd_dat  in  32  write data
- cmd_sel  in  4  byte selects
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready
- rsp_dat  out  32  read data (0 for writes and errors)
- rsp_err  out  1  1 = timeout abort
- wbm_cyc_o  out  1  Wishbone CYC
- wbm_stb_o  out  1  Wishbone STB
- wbm_we_o  out  1  Wishbone WE
- wbm_sel_o  out  4  Wishbone SEL
- wbm_adr_o  out  32  Wishbone ADR
- wbm_dat_o  out  32  Wishbone write data
- wbm_dat_i  in  32  Wishbone read data
- wbm_ack_i  in  1  Wishbone ACK
- err_count  out  8  saturating count of timeouts since reset

Behaviour:
- Reset (wb_rst_i high at a rising edge) returns the block to IDLE and clears every output to 0, including cmd_ready. Reset mid-transfer drops the command silently: CYC/STB go low the next cycle and no response is produced.
- All outputs are registered.

States:
- IDLE
  - cmd_ready=1 (it is 0 in every other state and during reset).
  - On cmd_valid&&cmd_ready, latch we/adr/dat/sel onto the wbm_* outputs, clear the timeout counter and go to BUS.
  - wbm_cyc_o and wbm_stb_o rise in the cycle after acceptance.
- BUS
  - wbm_cyc_o=wbm_stb_o=1. wbm_adr_o, wbm_dat_o, wbm_we_o and wbm_sel_o are held stable.
  - ACK sampled high: deassert CYC/STB at that edge (low in the next cycle). Load rsp_dat from wbm_dat_i for a read, or 0 for a write. rsp_err=0. Go to RESP.
  - ACK low with TIMEOUT!=0 and counter==TIMEOUT-1: deassert CYC/STB, rsp_dat=0, rsp_err=1, err_count+1 (saturating at 255), go to RESP. STB is therefore high for exactly TIMEOUT cycles.
  - ACK low otherwise: counter+1, stay in BUS.
  - ACK and timeout in the same cycle: ACK wins, no error.
- RESP
  - rsp_valid=1, with rsp_dat/rsp_err stable until rsp_ready is sampled high.
  - On rsp_valid&&rsp_ready, clear rsp_valid and go to IDLE; cmd_ready rises the next cycle.
  - A new command is never accepted while a response is pending.
- Latency: acceptance at edge N gives STB high from cycle N+1. ACK sampled at edge M gives rsp_valid high from cycle M+1. Minimum command-to-command spacing is 3 cycles with zero-wait ACK and rsp_ready held high.
- wbm_ack_i outside BUS is ignored.
- The wbm_* address/data/sel/we outputs keep their last values in IDLE and RESP. Only CYC/STB carry protocol meaning.
- Bursts, RTY, ERR and pipelined mode are out of scope.

Test Plan:
- Zero-wait write, adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF, slave ACKs in the first STB cycle -> CYC/STB high exactly 1 cycle, wbm_we_o=1, then rsp_valid with rsp_err=0 and rsp_dat=0.
- Read with 3 wait states, slave returns 0x1234_5678 -> STB high 4 cycles, rsp_dat=0x1234_5678, rsp_err=0, rsp_valid one cycle after ACK.
- TIMEOUT=8, slave never ACKs -> STB high exactly 8 cycles, then rsp_err=1, rsp_dat=0, err_count=1. A following good read completes normally.
- Backpressure: rsp_ready held low for 5 cycles with cmd_valid held high -> rsp_valid/rsp_dat stable and cmd_ready=0 throughout; second command accepted one cycle after the handshake.
- Reset asserted in the 2nd BUS cycle of a read -> CYC/STB/rsp_valid/cmd_ready low the next cycle, no response ever issued, err_count=0. A late ACK arriving after reset is ignored.
- ACK arrives on the cycle the timeout would fire (TIMEOUT=4, ACK in 4th STB cycle) -> rsp_err=0, data captured, err_count unchanged. With TIMEOUT=0 and 300 cycles of no ACK -> still in BUS with no error.
